// File: rtl/mul_share_arb_if.sv
// Bus between the shared-multiplier arbiter and its environment:
// requesters, result consumer and the multiplier instance.
interface mul_share_arb_if #(
  parameter int NBITS = 5,
  parameter int OBITS = 5,
  parameter int N_REQ = 4
) ();
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]           req;
  logic [N_REQ*(NBITS+1)-1:0] op_a;
  logic [N_REQ*(NBITS+1)-1:0] op_b;
  logic                       hold;
  logic [N_REQ-1:0]           gnt;
  logic [NBITS:0]             mul_a;
  logic [NBITS:0]             mul_b;
  logic [OBITS:0]             mul_res;
  logic                       res_valid;
  logic [IDW-1:0]             res_id;
  logic [OBITS:0]             res_data;
  logic                       busy;

  modport master (
    output req, op_a, op_b, hold, mul_res,
    input  gnt, mul_a, mul_b, res_valid, res_id, res_data, busy
  );

  modport slave (
    input  req, op_a, op_b, hold, mul_res,
    output gnt, mul_a, mul_b, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin time-sharing of one registered multiplier between N_REQ requesters,
// returning id-tagged products. Optional grant counters: MUL_SHARE_ARB_STATS_EN.
module mul_share_arb #(
  parameter int NBITS   = 5,
  parameter int OBITS   = 5,
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MUL_SHARE_ARB_STATS_EN
  input  logic                  clr_stats,
  output logic [N_REQ*16-1:0]   grant_cnt,
`endif
  mul_share_arb_if.slave        bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int OW  = NBITS + 1;

  logic [IDW-1:0]   r_rr_ptr;
  logic [NBITS:0]   r_mul_a;
  logic [NBITS:0]   r_mul_b;
  logic [MUL_LAT:0] r_tag_v;
  logic [IDW-1:0]   r_tag_id [MUL_LAT+1];
  logic             r_res_valid;
  logic [IDW-1:0]   r_res_id;
  logic [OBITS:0]   r_res_data;

  logic [N_REQ-1:0] w_gnt;
  logic             w_xfer;
  logic [IDW-1:0]   w_gnt_id;
  logic [NBITS:0]   w_op_a;
  logic [NBITS:0]   w_op_b;
  int unsigned      w_j;

  // Rotating search starting at r_rr_ptr; first set request wins.
  always_comb begin
    w_gnt    = '0;
    w_xfer   = 1'b0;
    w_gnt_id = '0;
    w_op_a   = '0;
    w_op_b   = '0;
    w_j      = 0;
    if (!rst && !bus.hold) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        w_j = (32'(r_rr_ptr) + k) % N_REQ;
        if (!w_xfer && bus.req[w_j]) begin
          w_xfer       = 1'b1;
          w_gnt[w_j]   = 1'b1;
          w_gnt_id     = IDW'(w_j);
          w_op_a       = bus.op_a[w_j*OW +: OW];
          w_op_b       = bus.op_b[w_j*OW +: OW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_tag_v     <= '0;
      for (int unsigned k = 0; k <= MUL_LAT; k++) r_tag_id[k] <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
    end else begin
      if (w_xfer) begin
        r_mul_a  <= w_op_a;
        r_mul_b  <= w_op_b;
        r_rr_ptr <= (w_gnt_id == IDW'(N_REQ-1)) ? '0 : w_gnt_id + 1'b1;
      end
      // Tag stage k holds the op granted k edges ago; last stage lines up with mul_res.
      r_tag_v     <= {r_tag_v[MUL_LAT-1:0], w_xfer};
      r_tag_id[0] <= w_gnt_id;
      for (int unsigned k = 1; k <= MUL_LAT; k++) r_tag_id[k] <= r_tag_id[k-1];
      r_res_valid <= r_tag_v[MUL_LAT];
      if (r_tag_v[MUL_LAT]) begin
        r_res_data <= bus.mul_res;
        r_res_id   <= r_tag_id[MUL_LAT];
      end
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_data  = r_res_data;
  assign bus.busy      = |r_tag_v;

`ifdef MUL_SHARE_ARB_STATS_EN
  logic [15:0] r_cnt [N_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (clr_stats)
          r_cnt[i] <= '0;
        else if (w_gnt[i] && r_cnt[i] != 16'hFFFF)
          r_cnt[i] <= r_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) grant_cnt[i*16 +: 16] = r_cnt[i];
  end
`endif
endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb: reference arbitration model predicts grants
// and pushes expected tagged products; a monitor pops them on res_valid.
module tb_mul_share_arb;
  localparam int NBITS   = 5;
  localparam int OBITS   = 5;
  localparam int N_REQ   = 4;
  localparam int MUL_LAT = 1;
  localparam int OW      = NBITS + 1;
  localparam int RW      = OBITS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_share_arb_if #(.NBITS(NBITS), .OBITS(OBITS), .N_REQ(N_REQ)) bus ();

`ifdef MUL_SHARE_ARB_STATS_EN
  logic                clr_stats = 1'b0;
  logic [N_REQ*16-1:0] grant_cnt;
`endif

  mul_share_arb #(.NBITS(NBITS), .OBITS(OBITS), .N_REQ(N_REQ), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MUL_SHARE_ARB_STATS_EN
    .clr_stats (clr_stats),
    .grant_cnt (grant_cnt),
`endif
    .bus       (bus)
  );

  // Multiplier stand-in with MUL_LAT register stages.
  logic [RW-1:0] mp [MUL_LAT];
  always @(posedge clk) begin
    mp[0] <= RW'(bus.mul_a * bus.mul_b);
    for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
  end
  assign bus.mul_res = mp[MUL_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] r, input int p);
    logic [N_REQ-1:0] one;
    one = 1;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (p + k) % N_REQ;
      if (r[j]) return one << j;
    end
    return '0;
  endfunction

  typedef struct {
    int            id;
    logic [RW-1:0] data;
    int            due;
  } exp_t;

  exp_t             sb[$];
  int               m_ptr     = 0;
  int               last_xfer = -100;
  logic [OW-1:0]    e_a = '0;
  logic [OW-1:0]    e_b = '0;
  logic [N_REQ-1:0] seen_gnt = '0;
`ifdef MUL_SHARE_ARB_STATS_EN
  int               m_cnt [N_REQ];
`endif

  // Reference model: grant prediction, operand/busy expectations, scoreboard push.
  always @(negedge clk) begin
    logic [N_REQ-1:0] eg;
    logic [RW-1:0]    p;
    int               id;
    if (rst) begin
      check("rst_gnt", bus.gnt, 0);
      check("rst_mul_a", bus.mul_a, 0);
      check("rst_mul_b", bus.mul_b, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_id", bus.res_id, 0);
      check("rst_res_data", bus.res_data, 0);
      check("rst_busy", bus.busy, 0);
      m_ptr = 0; last_xfer = -100; e_a = '0; e_b = '0; seen_gnt = '0;
      sb.delete();
`ifdef MUL_SHARE_ARB_STATS_EN
      for (int i = 0; i < N_REQ; i++) begin
        check("rst_cnt", grant_cnt[i*16 +: 16], 0);
        m_cnt[i] = 0;
      end
`endif
    end else begin
      check("mul_a", bus.mul_a, e_a);
      check("mul_b", bus.mul_b, e_b);
      check("busy", bus.busy, (cyc <= last_xfer + MUL_LAT));
      eg = bus.hold ? '0 : rr_pick(bus.req, m_ptr);
      check("gnt", bus.gnt, eg);
      seen_gnt = eg;
`ifdef MUL_SHARE_ARB_STATS_EN
      for (int i = 0; i < N_REQ; i++) check("grant_cnt", grant_cnt[i*16 +: 16], m_cnt[i]);
`endif
      if (eg != '0) begin
        id = 0;
        for (int i = 0; i < N_REQ; i++) if (eg[i]) id = i;
        e_a = bus.op_a[id*OW +: OW];
        e_b = bus.op_b[id*OW +: OW];
        p = e_a * e_b;
        m_ptr = (id + 1) % N_REQ;
        last_xfer = cyc + 1;
        sb.push_back('{id, p, cyc + 2 + MUL_LAT});
      end
`ifdef MUL_SHARE_ARB_STATS_EN
      for (int i = 0; i < N_REQ; i++) begin
        if (clr_stats) m_cnt[i] = 0;
        else if (eg[i] && m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
      end
`endif
    end
  end

  // Monitor: each scoreboard entry must appear exactly at its due cycle.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("res_valid_due", bus.res_valid, 1);
        check("res_id", bus.res_id, sb[0].id);
        check("res_data", bus.res_data, sb[0].data);
        void'(sb.pop_front());
      end else begin
        check("res_valid_idle", bus.res_valid, 0);
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  logic [N_REQ-1:0] seq3 [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [N_REQ-1:0] seq4 [3] = '{4'b0100, 4'b0001, 4'b0100};

  initial begin
    int nres;
    bus.req  = '1;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.hold = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.op_a[i*OW +: OW] = OW'(i + 1);
      bus.op_b[i*OW +: OW] = OW'(i + 5);
    end

    // Reset with all requesting, then plain rotation across six cycles.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_seq", bus.gnt, seq3[k]);
    end
    @(posedge clk); #1 bus.req = '0;
    repeat (4) @(posedge clk);

    // Single op 3*2 on requester 0.
    reset_dut();
    @(posedge clk); #1;
    bus.op_a[0 +: OW] = 3; bus.op_b[0 +: OW] = 2; bus.req = 4'b0001;
    @(negedge clk); check("single_gnt", bus.gnt, 4'b0001);
    @(posedge clk); #1 bus.req = '0;
    @(negedge clk); check("single_mul_a", bus.mul_a, 3); check("single_mul_b", bus.mul_b, 2);
    @(negedge clk); check("single_early", bus.res_valid, 0);
    @(negedge clk);
    check("single_valid", bus.res_valid, 1);
    check("single_id", bus.res_id, 0);
    check("single_data", bus.res_data, 6);
    @(negedge clk); check("single_pulse", bus.res_valid, 0);

    // Wrap fairness: last grant was requester 0.
    @(posedge clk); #1 bus.req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wrap_seq", bus.gnt, seq4[k]);
    end
    @(posedge clk); #1 bus.req = '0;
    repeat (4) @(posedge clk);

    // Two ops in flight, then hold: both results still delivered.
    reset_dut();
    @(posedge clk); #1 bus.req = '1;
    @(posedge clk);
    @(posedge clk); #1 bus.hold = 1'b1;
    @(negedge clk); check("hold_gnt", bus.gnt, 0);
    nres = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.res_valid) nres++;
    end
    check("hold_results", nres, 2);
    check("hold_busy_idle", bus.busy, 0);
    @(posedge clk); #1 bus.hold = 1'b0; bus.req = '0;

    // Reset while busy discards in-flight results.
    @(posedge clk); #1 bus.req = '1;
    @(negedge clk);
    @(posedge clk); #1 bus.req = '0;
    @(negedge clk); check("pre_rst_busy", bus.busy, 1);
    reset_dut();
    nres = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.res_valid) nres++;
    end
    check("post_rst_no_res", nres, 0);

    // Randomised traffic with occasional hold and abandoned requests.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      bus.hold = ($urandom_range(9) == 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (seen_gnt[i]) bus.req[i] = 1'b0;
        else if (bus.req[i] && $urandom_range(15) == 0) bus.req[i] = 1'b0;
        if (!bus.req[i] && $urandom_range(2) == 0) begin
          bus.req[i] = 1'b1;
          bus.op_a[i*OW +: OW] = OW'($urandom);
          bus.op_b[i*OW +: OW] = OW'($urandom);
        end
      end
    end
    @(posedge clk); #1 bus.hold = 1'b0; bus.req = '0;

`ifdef MUL_SHARE_ARB_STATS_EN
    @(posedge clk); #1 clr_stats = 1'b1; bus.req = '1;
    @(posedge clk); #1 clr_stats = 1'b0; bus.req = '0;
    @(negedge clk); check("clr_priority", grant_cnt, 0);
    @(posedge clk); #1 bus.req = 4'b0001;
    repeat (65540) @(posedge clk);
    #1 bus.req = '0;
    @(negedge clk); check("cnt_sat", grant_cnt[15:0], 16'hFFFF);
    reset_dut();
    @(negedge clk); check("cnt_after_rst", grant_cnt, 0);
`endif

    repeat (MUL_LAT + 4) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
